mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 143 ++++++++++++++
 tb/tb_mul_div_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at issue; HI/LO are written only when the cycle counter expires.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       op_q, op_n;
    logic [31:0]      a_q, a_n, b_q, b_n;
    logic [31:0]      hi_n, lo_n;
    logic             busy_n;

    // Result datapath, purely combinational on the latched operands
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, den_s, den_u;
    logic [31:0] qs_mag, rs_mag, q_s, r_s, q_u, r_u;
    logic        b_zero;

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes; divisor forced to 1 when zero since that result is discarded
    assign b_zero = (b_q == 32'd0);
    assign abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    assign abs_b  = b_q[31] ? (32'd0 - b_q) : b_q;
    assign den_s  = b_zero ? 32'd1 : abs_b;
    assign den_u  = b_zero ? 32'd1 : b_q;
    assign qs_mag = abs_a / den_s;
    assign rs_mag = abs_a % den_s;
    assign q_s    = (a_q[31] ^ b_q[31]) ? (32'd0 - qs_mag) : qs_mag;
    assign r_s    = a_q[31] ? (32'd0 - rs_mag) : rs_mag;
    assign q_u    = a_q / den_u;
    assign r_u    = a_q % den_u;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            busy  <= busy_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        busy_n  = busy;
        hi_n    = hi;
        lo_n    = lo;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            op_n    = op;
                            a_n     = a;
                            b_n     = b;
                            cnt_n   = (op == OP_MULT || op == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                            state_n = RUN;
                            busy_n  = 1'b1;
                        end
                        OP_MTHI: hi_n = a;
                        OP_MTLO: lo_n = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Final count: commit the result and stop the counter at zero
                if (cnt <= CNT_W'(1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    case (op_q)
                        OP_MULT:  {hi_n, lo_n} = prod_s;
                        OP_MULTU: {hi_n, lo_n} = prod_u;
                        OP_DIV: begin
                            if (!b_zero) begin
                                hi_n = r_s;
                                lo_n = q_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!b_zero) begin
                                hi_n = r_u;
                                lo_n = q_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: hand-computed HI/LO results and busy timing.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, check busy and unchanged HI/LO each cycle, then the result.
    // inj_k: cycle in which an mthi is attempted (0 = none); fin_inj: attempt mtlo on the completion edge.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int n, input logic [31:0] eh,
                          input logic [31:0] el, input int inj_k, input bit fin_inj);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~av;
        b = 32'h5A5A_5A5A;
        for (int k = 1; k < n; k++) begin
            check({tag, "/busy"}, {31'd0, busy}, 32'd1);
            check({tag, "/hi_hold"}, hi, m_hi);
            check({tag, "/lo_hold"}, lo, m_lo);
            if (k == inj_k) begin
                start = 1'b1; op = 3'd5; a = 32'h1234_5678;
            end
            tick();
            start = 1'b0;
        end
        check({tag, "/busy_last"}, {31'd0, busy}, 32'd1);
        if (fin_inj) begin
            start = 1'b1; op = 3'd6; a = 32'h0000_DEAD;
        end
        tick();
        start = 1'b0;
        check({tag, "/busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "/hi"}, hi, eh);
        check({tag, "/lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic move(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] eh, input logic [31:0] el);
        op = o; a = av; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "/busy"}, {31'd0, busy}, 32'd0);
        check({tag, "/hi"}, hi, eh);
        check({tag, "/lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        tick();
        tick();
        check("reset/hi", hi, 32'd0);
        check("reset/lo", lo, 32'd0);
        check("reset/busy", {31'd0, busy}, 32'd0);

        // start ignored while reset is held
        op = 3'd5; a = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        check("reset_start/hi", hi, 32'd0);
        check("reset_start/busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 1'b0);
        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
        run_op("mult_inj", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000, 3, 1'b1);
        move("mtlo_after", 3'd6, 32'h0000_ABCD, 32'h0000_0001, 32'h0000_ABCD);
        move("op7_none", 3'd7, 32'h0000_5555, 32'h0000_0001, 32'h0000_ABCD);
        move("op0_none", 3'd0, 32'h0000_5555, 32'h0000_0001, 32'h0000_ABCD);
        run_op("mult_mix", 3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 5, 32'hC000_0000, 32'h8000_0000, 0, 1'b0);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 0, 1'b0);
        move("mthi", 3'd5, 32'h0000_0011, 32'h0000_0011, 32'hFFFF_FFFD);
        move("mtlo", 3'd6, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022);
        run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 32'h0000_0011, 32'h0000_0022, 0, 1'b0);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 0, 1'b0);
        run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E, 0, 1'b0);

        // Async reset pulse mid-divide, then confirm nothing is written afterwards
        op = 3'd3; a = 32'd100; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("abort/hi", hi, 32'd0);
        check("abort/lo", lo, 32'd0);
        check("abort/busy", {31'd0, busy}, 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("post_abort/hi", hi, 32'd0);
            check("post_abort/lo", lo, 32'd0);
            check("post_abort/busy", {31'd0, busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
